axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
Two-master AXI4 read-channel arbiter that shares the single memory read port between the instruction cache (master 0) and the LSU (master 1). It sits between both masters and the xbar/SoC read port. It grants one master per transaction and locks that grant from AR issue until the last R beat. The write channel does not pass through this block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
ID_W, 4, AXI ID width

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_m0_arvalid/araddr/arid/arlen/arsize/arburst  in  1/ADDR_W/ID_W/8/3/2  icache AR request
o_m0_arready  out  1  icache AR accept
o_m0_rvalid/rdata/rresp/rid/rlast  out  1/DATA_W/2/ID_W/1  icache R beat
i_m0_rready  in  1  icache R accept
i_m1_arvalid/araddr/arid/arlen/arsize/arburst  in  1/ADDR_W/ID_W/8/3/2  LSU AR request
o_m1_arready  out  1  LSU AR accept
o_m1_rvalid/rdata/rresp/rid/rlast  out  1/DATA_W/2/ID_W/1  LSU R beat
i_m1_rready  in  1  LSU R accept
o_s_arvalid/araddr/arid/arlen/arsize/arburst  out  1/ADDR_W/ID_W/8/3/2  downstream AR
i_s_arready  in  1  downstream AR accept
i_s_rvalid/rdata/rresp/rid/rlast  in  1/DATA_W/2/ID_W/1  downstream R beat
o_s_rready  out  1  downstream R accept
o_busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, grant=0, last_grant=0 (master 0), beat counter=0. All outputs are 0 in the reset cycle and in IDLE.
- State machine: IDLE, ADDR, DATA.
- IDLE: if any i_mX_arvalid is set, register the winner into grant and go to ADDR. No AR is driven in this cycle. Latency is 1 cycle from a request to o_s_arvalid.
- ADDR: o_s_ar* is driven combinationally from the granted master, with o_s_arid = the master's own arid. o_mG_arready = i_s_arready; the other master's arready = 0. On o_s_arvalid && i_s_arready: latch arlen into the beat counter and go to DATA.
- DATA: the downstream R channel routes to the granted master only. o_mG_r* = i_s_r*, o_s_rready = i_mG_rready. The non-granted master sees rvalid = 0 and arready = 0.
  - Each R handshake decrements the beat counter.
  - On a handshake with i_s_rlast = 1: go to IDLE and update last_grant = grant.
  - A bubble of one IDLE cycle always occurs between transactions.
- Beat-count rule: if i_s_rlast arrives early or late relative to arlen, rlast wins. The counter is informational only and is cleared on return to IDLE.
- Arbitration (default fixed priority): master 1 (LSU) beats master 0 when both request in the same IDLE cycle.
- Requests during ADDR/DATA are not accepted. Masters hold arvalid and the AR fields stable until accepted; the arbiter does not buffer AR fields.
- Master flush/abort: masters must keep rready and drain the full burst. The arbiter never terminates a burst early.
- Reset mid-burst: the arbiter returns to IDLE immediately. Downstream is reset by the same i_reset.
- rresp is passed through unmodified. Error handling belongs to the masters.

Optional Feature:
ARB_RR_EN — when defined, on a simultaneous request the master != last_grant wins (round-robin). A single requester always wins regardless of last_grant. When undefined, fixed priority applies (LSU over icache) and last_grant is unused.

Decomposition:
- Shared package axi_rd_arb_pkg holds:
  - state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2)
  - master index constants M_ICACHE=1'b0, M_LSU=1'b1
  - AXI burst constants FIXED=2'b00, INCR=2'b01
- One natural sub-module: arb_pick_2, a combinational winner selection (fixed or RR), reused by a future write arbiter.

Test Plan:
- Icache only: m0 araddr 0x30000008, arlen 1, INCR, rvalid on two beats with rlast on the second -> o_s_arvalid rises 1 cycle after request. m0 receives both beats (rdata 0x00000413, 0x00100093). m1 rvalid stays 0. o_busy returns to 0 after rlast.
- Simultaneous request, m0 0x30000000, m1 0x0f000010 arlen 0 -> m1 is granted first with o_s_araddr 0x0f000010. After its rlast and the 1-cycle bubble, m0 is granted.
- ARB_RR_EN defined, both masters request continuously for 4 transactions -> grants alternate m1, m0, m1, m0.
- Request during burst: m1 asserts arvalid while m0's DATA is 2 beats in -> o_m1_arready stays 0 until m0's rlast. m1 is granted in the following IDLE. m1's AR fields are held unchanged.
- Backpressure: i_s_arready low 5 cycles; then i_m0_rready low on beat 1 -> o_s_arvalid stays high with fields stable. o_s_rready = 0 while i_m0_rready = 0. No beat is lost or duplicated.
- i_reset asserted mid-DATA -> next cycle state = IDLE and all valid/ready outputs = 0. A new m0 request after reset is granted normally.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the AXI read-channel arbiter: FSM encoding,
// master indices and AXI burst type constants.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic M_ICACHE = 1'b0;
  localparam logic M_LSU    = 1'b1;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

endpackage

// File: rtl/arb_pick_2.sv
// Two-requester winner selection: fixed priority (LSU first) or round-robin
// against the previous grant. Purely combinational.
module arb_pick_2
  import axi_rd_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       win
);

  always_comb begin
    valid = |req;
    // A lone requester wins outright; only a tie consults the policy.
    if (req == 2'b11) begin
      win = RR_EN ? ~last : M_LSU;
    end else begin
      win = req[1];
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter (icache = master 0, LSU = master 1) sharing one
// downstream read port; the grant is held from AR issue to the last R beat.
// Define ARB_RR_EN for round-robin on ties; otherwise the LSU has priority.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_m0_arvalid,
  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic [ID_W-1:0]   i_m0_arid,
  input  logic [7:0]        i_m0_arlen,
  input  logic [2:0]        i_m0_arsize,
  input  logic [1:0]        i_m0_arburst,
  output logic              o_m0_arready,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic [ID_W-1:0]   o_m0_rid,
  output logic              o_m0_rlast,
  input  logic              i_m0_rready,
  input  logic              i_m1_arvalid,
  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic [ID_W-1:0]   i_m1_arid,
  input  logic [7:0]        i_m1_arlen,
  input  logic [2:0]        i_m1_arsize,
  input  logic [1:0]        i_m1_arburst,
  output logic              o_m1_arready,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic [ID_W-1:0]   o_m1_rid,
  output logic              o_m1_rlast,
  input  logic              i_m1_rready,
  output logic              o_s_arvalid,
  output logic [ADDR_W-1:0] o_s_araddr,
  output logic [ID_W-1:0]   o_s_arid,
  output logic [7:0]        o_s_arlen,
  output logic [2:0]        o_s_arsize,
  output logic [1:0]        o_s_arburst,
  input  logic              i_s_arready,
  input  logic              i_s_rvalid,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  input  logic [ID_W-1:0]   i_s_rid,
  input  logic              i_s_rlast,
  output logic              o_s_rready,
  output logic              o_busy
);

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  state_t     state_reg, state_next;
  logic       grant_reg, grant_next;
  logic       last_grant_reg, last_grant_next;
  logic [7:0] beat_cnt_reg, beat_cnt_next;
  logic       pick_valid, pick_win;

  arb_pick_2 #(.RR_EN(RR)) u_pick (
    .req   ({i_m1_arvalid, i_m0_arvalid}),
    .last  (last_grant_reg),
    .valid (pick_valid),
    .win   (pick_win)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      grant_reg      <= M_ICACHE;
      last_grant_reg <= M_ICACHE;
      beat_cnt_reg   <= 8'd0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_win;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (o_s_arvalid && i_s_arready) begin
          beat_cnt_next = grant_reg ? i_m1_arlen : i_m0_arlen;
          state_next    = DATA;
        end
      end
      DATA: begin
        // rlast alone ends the burst; the counter is only a progress indicator.
        if (i_s_rvalid && o_s_rready) begin
          beat_cnt_next = beat_cnt_reg - 8'd1;
          if (i_s_rlast) begin
            beat_cnt_next   = 8'd0;
            last_grant_next = grant_reg;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_m0_arready = 1'b0;
    o_m1_arready = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = 2'b00;
    o_m0_rid     = '0;
    o_m0_rlast   = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = 2'b00;
    o_m1_rid     = '0;
    o_m1_rlast   = 1'b0;
    o_s_arvalid  = 1'b0;
    o_s_araddr   = '0;
    o_s_arid     = '0;
    o_s_arlen    = 8'd0;
    o_s_arsize   = 3'd0;
    o_s_arburst  = 2'b00;
    o_s_rready   = 1'b0;
    o_busy       = 1'b0;
    // Outputs are forced quiet during reset, whatever state the FSM was in.
    if (!i_reset) begin
      o_busy = (state_reg != IDLE);
      case (state_reg)
        ADDR: begin
          o_s_arvalid = grant_reg ? i_m1_arvalid : i_m0_arvalid;
          o_s_araddr  = grant_reg ? i_m1_araddr  : i_m0_araddr;
          o_s_arid    = grant_reg ? i_m1_arid    : i_m0_arid;
          o_s_arlen   = grant_reg ? i_m1_arlen   : i_m0_arlen;
          o_s_arsize  = grant_reg ? i_m1_arsize  : i_m0_arsize;
          o_s_arburst = grant_reg ? i_m1_arburst : i_m0_arburst;
          o_m0_arready = !grant_reg && i_s_arready;
          o_m1_arready =  grant_reg && i_s_arready;
        end
        DATA: begin
          o_s_rready = grant_reg ? i_m1_rready : i_m0_rready;
          if (grant_reg) begin
            o_m1_rvalid = i_s_rvalid;
            o_m1_rdata  = i_s_rdata;
            o_m1_rresp  = i_s_rresp;
            o_m1_rid    = i_s_rid;
            o_m1_rlast  = i_s_rlast;
          end else begin
            o_m0_rvalid = i_s_rvalid;
            o_m0_rdata  = i_s_rdata;
            o_m0_rresp  = i_s_rresp;
            o_m0_rid    = i_s_rid;
            o_m0_rlast  = i_s_rlast;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: one task per scenario, each with inline
// comparisons against hand-computed values.
module tb_axi_rd_arbiter;
  import axi_rd_arb_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_m0_arvalid, i_m1_arvalid;
  logic [31:0] i_m0_araddr, i_m1_araddr;
  logic [3:0]  i_m0_arid, i_m1_arid;
  logic [7:0]  i_m0_arlen, i_m1_arlen;
  logic [2:0]  i_m0_arsize, i_m1_arsize;
  logic [1:0]  i_m0_arburst, i_m1_arburst;
  logic        o_m0_arready, o_m1_arready;
  logic        o_m0_rvalid, o_m1_rvalid;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [1:0]  o_m0_rresp, o_m1_rresp;
  logic [3:0]  o_m0_rid, o_m1_rid;
  logic        o_m0_rlast, o_m1_rlast;
  logic        i_m0_rready, i_m1_rready;
  logic        o_s_arvalid;
  logic [31:0] o_s_araddr;
  logic [3:0]  o_s_arid;
  logic [7:0]  o_s_arlen;
  logic [2:0]  o_s_arsize;
  logic [1:0]  o_s_arburst;
  logic        i_s_arready;
  logic        i_s_rvalid;
  logic [31:0] i_s_rdata;
  logic [1:0]  i_s_rresp;
  logic [3:0]  i_s_rid;
  logic        i_s_rlast;
  logic        o_s_rready;
  logic        o_busy;

  int errors = 0;
  int checks = 0;
  int m0_beats = 0;

  always #5 i_clock = ~i_clock;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_m0_arvalid(i_m0_arvalid), .i_m0_araddr(i_m0_araddr), .i_m0_arid(i_m0_arid),
    .i_m0_arlen(i_m0_arlen), .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst),
    .o_m0_arready(o_m0_arready), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .o_m0_rresp(o_m0_rresp), .o_m0_rid(o_m0_rid), .o_m0_rlast(o_m0_rlast),
    .i_m0_rready(i_m0_rready),
    .i_m1_arvalid(i_m1_arvalid), .i_m1_araddr(i_m1_araddr), .i_m1_arid(i_m1_arid),
    .i_m1_arlen(i_m1_arlen), .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst),
    .o_m1_arready(o_m1_arready), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_m1_rresp(o_m1_rresp), .o_m1_rid(o_m1_rid), .o_m1_rlast(o_m1_rlast),
    .i_m1_rready(i_m1_rready),
    .o_s_arvalid(o_s_arvalid), .o_s_araddr(o_s_araddr), .o_s_arid(o_s_arid),
    .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize), .o_s_arburst(o_s_arburst),
    .i_s_arready(i_s_arready),
    .i_s_rvalid(i_s_rvalid), .i_s_rdata(i_s_rdata), .i_s_rresp(i_s_rresp),
    .i_s_rid(i_s_rid), .i_s_rlast(i_s_rlast), .o_s_rready(o_s_rready),
    .o_busy(o_busy)
  );

  // Counts R beats actually delivered to master 0 (both sides ready).
  always @(posedge i_clock)
    if (o_m0_rvalid && i_m0_rready && o_s_rready) m0_beats <= m0_beats + 1;

  task automatic step();
    @(posedge i_clock);
    #2;
  endtask

  task automatic s_beat(input logic [31:0] d, input logic l);
    i_s_rvalid = 1'b1;
    i_s_rdata  = d;
    i_s_rlast  = l;
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_m0_arvalid = 1'b1;
    i_s_rvalid = 1'b1;
    step();
    #1;
    checks++; if ({o_s_arvalid, o_busy, o_m0_rvalid, o_s_rready, o_m0_arready} !== 5'b0) begin
      errors++; $display("FAIL rst_outputs got=%b want=00000", {o_s_arvalid, o_busy, o_m0_rvalid, o_s_rready, o_m0_arready}); end
    step();
    i_m0_arvalid = 1'b0;
    i_s_rvalid = 1'b0;
    i_reset = 1'b0;
    #1;
    checks++; if ({o_busy, o_s_arvalid, o_m1_arready} !== 3'b0) begin
      errors++; $display("FAIL rst_idle got=%b want=000", {o_busy, o_s_arvalid, o_m1_arready}); end
    $display("txn reset done");
  endtask

  task automatic test_icache_only();
    i_m0_arvalid = 1'b1; i_m0_araddr = 32'h3000_0008; i_m0_arid = 4'h3;
    i_m0_arlen = 8'd1; i_m0_arsize = 3'd2; i_m0_arburst = INCR;
    #1;
    checks++; if (o_s_arvalid !== 1'b0) begin errors++; $display("FAIL ic_idle_ar got=%b want=0", o_s_arvalid); end
    step(); #1;
    checks++; if ({o_s_arvalid, o_busy} !== 2'b11) begin errors++; $display("FAIL ic_ar_valid got=%b want=11", {o_s_arvalid, o_busy}); end
    checks++; if (o_s_araddr !== 32'h3000_0008 || o_s_arid !== 4'h3 || o_s_arlen !== 8'd1 || o_s_arburst !== INCR) begin
      errors++; $display("FAIL ic_ar_fields addr=%h id=%h len=%0d burst=%b want 30000008/3/1/01", o_s_araddr, o_s_arid, o_s_arlen, o_s_arburst); end
    checks++; if (o_m0_arready !== 1'b0) begin errors++; $display("FAIL ic_arready_low got=%b want=0", o_m0_arready); end
    i_s_arready = 1'b1; #1;
    checks++; if ({o_m0_arready, o_m1_arready} !== 2'b10) begin errors++; $display("FAIL ic_arready got=%b want=10", {o_m0_arready, o_m1_arready}); end
    step();
    i_m0_arvalid = 1'b0; i_s_arready = 1'b0; i_m0_rready = 1'b1; i_s_rid = 4'h3; i_s_rresp = 2'b00;
    s_beat(32'h0000_0413, 1'b0);
    checks++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'h0000_0413 || o_m0_rid !== 4'h3 || o_m0_rlast !== 1'b0) begin
      errors++; $display("FAIL ic_beat0 v=%b d=%h id=%h l=%b want 1/00000413/3/0", o_m0_rvalid, o_m0_rdata, o_m0_rid, o_m0_rlast); end
    checks++; if ({o_m1_rvalid, o_s_rready} !== 2'b01) begin errors++; $display("FAIL ic_route got=%b want=01", {o_m1_rvalid, o_s_rready}); end
    step();
    i_s_rresp = 2'b10;
    s_beat(32'h0010_0093, 1'b1);
    checks++; if (o_m0_rdata !== 32'h0010_0093 || o_m0_rlast !== 1'b1 || o_m0_rresp !== 2'b10) begin
      errors++; $display("FAIL ic_beat1 d=%h l=%b resp=%b want 00100093/1/10", o_m0_rdata, o_m0_rlast, o_m0_rresp); end
    step();
    i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_s_rresp = 2'b00; #1;
    checks++; if ({o_busy, o_m0_rvalid} !== 2'b00) begin errors++; $display("FAIL ic_done got=%b want=00", {o_busy, o_m0_rvalid}); end
    $display("txn icache addr=30000008 len=1 complete");
  endtask

  task automatic test_simultaneous();
    i_m0_araddr = 32'h3000_0000; i_m0_arid = 4'h1; i_m0_arlen = 8'd0;
    i_m1_araddr = 32'h0f00_0010; i_m1_arid = 4'h2; i_m1_arlen = 8'd0;
    i_m1_arsize = 3'd2; i_m1_arburst = INCR;
    i_m0_arvalid = 1'b1; i_m1_arvalid = 1'b1; i_m1_rready = 1'b1;
    #1; step(); #1;
    checks++; if (o_s_araddr !== 32'h0f00_0010 || o_s_arid !== 4'h2) begin
      errors++; $display("FAIL sim_first addr=%h id=%h want 0f000010/2", o_s_araddr, o_s_arid); end
    i_s_arready = 1'b1; #1;
    checks++; if ({o_m0_arready, o_m1_arready} !== 2'b01) begin errors++; $display("FAIL sim_arready got=%b want=01", {o_m0_arready, o_m1_arready}); end
    step();
    i_m1_arvalid = 1'b0; i_s_arready = 1'b0; i_s_rid = 4'h2;
    s_beat(32'hcafe_0001, 1'b1);
    checks++; if ({o_m1_rvalid, o_m0_rvalid} !== 2'b10 || o_m1_rdata !== 32'hcafe_0001) begin
      errors++; $display("FAIL sim_m1_beat v=%b d=%h want 10/cafe0001", {o_m1_rvalid, o_m0_rvalid}, o_m1_rdata); end
    step();
    i_s_rvalid = 1'b0; #1;
    checks++; if ({o_busy, o_s_arvalid} !== 2'b00) begin errors++; $display("FAIL sim_bubble got=%b want=00", {o_busy, o_s_arvalid}); end
    step(); #1;
    checks++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== 32'h3000_0000) begin
      errors++; $display("FAIL sim_second v=%b addr=%h want 1/30000000", o_s_arvalid, o_s_araddr); end
    i_s_arready = 1'b1;
    step();
    i_m0_arvalid = 1'b0; i_s_arready = 1'b0; i_s_rid = 4'h1;
    s_beat(32'hcafe_0002, 1'b1);
    checks++; if ({o_m0_rvalid, o_m1_rvalid} !== 2'b10) begin errors++; $display("FAIL sim_m0_beat got=%b want=10", {o_m0_rvalid, o_m1_rvalid}); end
    step();
    i_s_rvalid = 1'b0;
    $display("txn simultaneous m1 then m0 complete");
  endtask

  task automatic test_back_to_back();
    logic exp;
    i_m0_arvalid = 1'b1; i_m1_arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp = (k % 2 == 0);
`else
      exp = 1'b1;
`endif
      #1; step(); #1;
      checks++; if (o_s_araddr !== (exp ? 32'h0f00_0010 : 32'h3000_0000)) begin
        errors++; $display("FAIL b2b_grant%0d addr=%h want_master=%0d", k, o_s_araddr, exp); end
      i_s_arready = 1'b1;
      step();
      i_s_arready = 1'b0;
      s_beat(32'h0000_0100 + k, 1'b1);
      checks++; if ((exp ? o_m1_rvalid : o_m0_rvalid) !== 1'b1 || (exp ? o_m0_rvalid : o_m1_rvalid) !== 1'b0) begin
        errors++; $display("FAIL b2b_route%0d m0=%b m1=%b want_master=%0d", k, o_m0_rvalid, o_m1_rvalid, exp); end
      step();
      i_s_rvalid = 1'b0;
      $display("txn back_to_back %0d granted m%0d", k, exp);
    end
    i_m0_arvalid = 1'b0; i_m1_arvalid = 1'b0;
  endtask

  task automatic test_request_during_burst();
    i_m0_araddr = 32'h3000_0040; i_m0_arid = 4'h4; i_m0_arlen = 8'd3; i_m0_arvalid = 1'b1;
    #1; step();
    i_s_arready = 1'b1;
    step();
    i_m0_arvalid = 1'b0;
    s_beat(32'hd000_0000, 1'b0); step();
    s_beat(32'hd000_0001, 1'b0); step();
    i_m1_arvalid = 1'b1; i_m1_araddr = 32'h0f00_0020; i_m1_arid = 4'h5; i_m1_arlen = 8'd0;
    s_beat(32'hd000_0002, 1'b0);
    checks++; if (o_m1_arready !== 1'b0 || o_m0_rvalid !== 1'b1) begin
      errors++; $display("FAIL rdb_block3 arready=%b rvalid=%b want 0/1", o_m1_arready, o_m0_rvalid); end
    step();
    s_beat(32'hd000_0003, 1'b1);
    checks++; if (o_m1_arready !== 1'b0 || o_m0_rlast !== 1'b1) begin
      errors++; $display("FAIL rdb_block4 arready=%b rlast=%b want 0/1", o_m1_arready, o_m0_rlast); end
    step();
    i_s_rvalid = 1'b0; i_s_arready = 1'b0; #1;
    checks++; if ({o_m1_arready, o_busy} !== 2'b00) begin errors++; $display("FAIL rdb_idle got=%b want=00", {o_m1_arready, o_busy}); end
    step(); #1;
    checks++; if (o_s_araddr !== 32'h0f00_0020 || o_s_arid !== 4'h5) begin
      errors++; $display("FAIL rdb_m1_ar addr=%h id=%h want 0f000020/5", o_s_araddr, o_s_arid); end
    i_s_arready = 1'b1; #1;
    checks++; if (o_m1_arready !== 1'b1) begin errors++; $display("FAIL rdb_m1_arready got=%b want=1", o_m1_arready); end
    step();
    i_m1_arvalid = 1'b0; i_s_arready = 1'b0;
    s_beat(32'hd000_0010, 1'b1);
    checks++; if (o_m1_rvalid !== 1'b1) begin errors++; $display("FAIL rdb_m1_beat got=%b want=1", o_m1_rvalid); end
    step();
    i_s_rvalid = 1'b0;
    $display("txn request_during_burst complete");
  endtask

  task automatic test_backpressure();
    int beats0;
    i_m0_araddr = 32'h3000_0080; i_m0_arid = 4'h6; i_m0_arlen = 8'd1; i_m0_arvalid = 1'b1;
    #1; step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== 32'h3000_0080 || o_s_arlen !== 8'd1 || o_m0_arready !== 1'b0) begin
        errors++; $display("FAIL bp_ar_hold%0d v=%b addr=%h len=%0d rdy=%b", c, o_s_arvalid, o_s_araddr, o_s_arlen, o_m0_arready); end
      step();
    end
    i_s_arready = 1'b1; #1;
    step();
    beats0 = m0_beats;
    i_m0_arvalid = 1'b0; i_s_arready = 1'b0; i_m0_rready = 1'b0;
    s_beat(32'hb000_0000, 1'b0);
    checks++; if (o_s_rready !== 1'b0 || o_m0_rvalid !== 1'b1) begin
      errors++; $display("FAIL bp_rready_low rready=%b rvalid=%b want 0/1", o_s_rready, o_m0_rvalid); end
    step();
    i_m0_rready = 1'b1; #1;
    checks++; if (o_s_rready !== 1'b1 || o_busy !== 1'b1 || o_m0_rdata !== 32'hb000_0000) begin
      errors++; $display("FAIL bp_resume rready=%b busy=%b d=%h want 1/1/b0000000", o_s_rready, o_busy, o_m0_rdata); end
    step();
    s_beat(32'hb000_0001, 1'b1);
    step();
    i_s_rvalid = 1'b0; i_s_rlast = 1'b0; #1;
    checks++; if (o_busy !== 1'b0 || (m0_beats - beats0) !== 2) begin
      errors++; $display("FAIL bp_beats busy=%b beats=%0d want 0/2", o_busy, m0_beats - beats0); end
    $display("txn backpressure complete");
  endtask

  task automatic test_reset_mid_burst();
    i_m0_araddr = 32'h3000_00c0; i_m0_arlen = 8'd3; i_m0_arvalid = 1'b1;
    #1; step();
    i_s_arready = 1'b1;
    step();
    i_m0_arvalid = 1'b0; i_s_arready = 1'b0;
    s_beat(32'he000_0000, 1'b0); step();
    s_beat(32'he000_0001, 1'b0);
    i_reset = 1'b1; #1;
    checks++; if ({o_m0_rvalid, o_s_rready, o_busy} !== 3'b000) begin
      errors++; $display("FAIL rmb_reset_cycle got=%b want=000", {o_m0_rvalid, o_s_rready, o_busy}); end
    step();
    i_reset = 1'b0; i_s_rvalid = 1'b0; #1;
    checks++; if ({o_busy, o_s_arvalid, o_s_rready, o_m0_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL rmb_idle got=%b want=0000", {o_busy, o_s_arvalid, o_s_rready, o_m0_rvalid}); end
    i_m0_araddr = 32'h3000_0100; i_m0_arlen = 8'd0; i_m0_arvalid = 1'b1;
    #1; step(); #1;
    checks++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== 32'h3000_0100) begin
      errors++; $display("FAIL rmb_new_ar v=%b addr=%h want 1/30000100", o_s_arvalid, o_s_araddr); end
    i_s_arready = 1'b1;
    step();
    i_m0_arvalid = 1'b0; i_s_arready = 1'b0;
    s_beat(32'he000_0010, 1'b1);
    checks++; if (o_m0_rvalid !== 1'b1) begin errors++; $display("FAIL rmb_new_beat got=%b want=1", o_m0_rvalid); end
    step();
    i_s_rvalid = 1'b0; #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmb_done got=%b want=0", o_busy); end
    $display("txn reset_mid_burst complete");
  endtask

  initial begin
    i_reset = 1'b1;
    i_m0_arvalid = 1'b0; i_m0_araddr = '0; i_m0_arid = '0; i_m0_arlen = '0; i_m0_arsize = 3'd2; i_m0_arburst = INCR;
    i_m1_arvalid = 1'b0; i_m1_araddr = '0; i_m1_arid = '0; i_m1_arlen = '0; i_m1_arsize = 3'd2; i_m1_arburst = INCR;
    i_m0_rready = 1'b0; i_m1_rready = 1'b0;
    i_s_arready = 1'b0; i_s_rvalid = 1'b0; i_s_rdata = '0; i_s_rresp = '0; i_s_rid = '0; i_s_rlast = 1'b0;
    test_reset();
    test_icache_only();
    test_simultaneous();
    test_back_to_back();
    test_request_during_burst();
    test_backpressure();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
